// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared state type and PCSrc encodings for the interrupt sequencer
package irq_pkg;

  typedef enum logic {IDLE, IN_ISR} irq_state_t;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_RES = 2'b01;
  localparam logic [1:0] PCSRC_INT = 2'b10;
  localparam logic [1:0] PCSRC_EPC = 2'b11;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-wins priority encoder with valid flag
module irq_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_req,
  output logic [W-1:0] o_idx,
  output logic         o_valid
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - edge-latched fixed-priority interrupt sequencer overriding PCSrc
// Optional IRQ_SYNC_EN: adds a 2-flop synchronizer on irq_in ahead of edge detect.
module irq_controller
  import irq_pkg::*;
#(
  parameter int N_IRQ    = 4,
  parameter int IRQ_ID_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_IRQ-1:0]    irq_in,
  input  logic [N_IRQ-1:0]    irq_mask,
  input  logic                gie,
  input  logic [1:0]          pc_src_in,
  input  logic [31:0]         pc_plus4,
  input  logic                iret,
  output logic [1:0]          pc_src_out,
  output logic [31:0]         epc,
  output logic [IRQ_ID_W-1:0] irq_id,
  output logic [N_IRQ-1:0]    irq_ack,
  output logic                in_isr
);

  irq_state_t          r_state;
  irq_state_t          w_state_next;
  logic [N_IRQ-1:0]    w_irq_s;
  logic [N_IRQ-1:0]    r_irq_prev;
  logic [N_IRQ-1:0]    r_pending;
  logic [N_IRQ-1:0]    w_edge;
  logic [N_IRQ-1:0]    w_eligible;
  logic [N_IRQ-1:0]    w_onehot;
  logic [N_IRQ-1:0]    w_clr;
  logic [IRQ_ID_W-1:0] w_win_idx;
  logic                w_win_valid;
  logic                w_take;
  logic                w_ret;
  logic [31:0]         r_epc;
  logic [IRQ_ID_W-1:0] r_irq_id;

`ifdef IRQ_SYNC_EN
  logic [N_IRQ-1:0] r_sync1;
  logic [N_IRQ-1:0] r_sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= irq_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_irq_s = r_sync2;
`else
  assign w_irq_s = irq_in;
`endif

  assign w_edge     = w_irq_s & ~r_irq_prev;
  assign w_eligible = r_pending & ~irq_mask;

  irq_prio_enc #(
    .N (N_IRQ),
    .W (IRQ_ID_W)
  ) u_prio (
    .i_req   (w_eligible),
    .o_idx   (w_win_idx),
    .o_valid (w_win_valid)
  );

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      w_onehot[i] = (w_win_idx == IRQ_ID_W'(i));
    end
  end

  // Only dispatch at a plain sequential boundary so the return address is always pc_plus4.
  assign w_take = !reset && (r_state == IDLE) && gie && w_win_valid
                  && (pc_src_in == PCSRC_SEQ) && !iret;
  assign w_ret  = !reset && (r_state == IN_ISR) && iret;
  assign w_clr  = w_take ? w_onehot : '0;

  always_comb begin
    w_state_next = r_state;
    pc_src_out   = pc_src_in;
    irq_ack      = '0;
    case (r_state)
      IDLE: begin
        if (w_take) begin
          w_state_next = IN_ISR;
          pc_src_out   = PCSRC_INT;
          irq_ack      = w_onehot;
        end
      end
      IN_ISR: begin
        if (w_ret) begin
          w_state_next = IDLE;
          pc_src_out   = PCSRC_EPC;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_irq_prev <= '1;
      r_pending  <= '0;
      r_epc      <= '0;
      r_irq_id   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_irq_prev <= w_irq_s;
      // A fresh edge on the line being acknowledged re-arms it.
      r_pending  <= (r_pending & ~w_clr) | w_edge;
      if (w_take) begin
        r_epc    <= pc_plus4;
        r_irq_id <= w_win_idx;
      end
    end
  end

  assign epc    = r_epc;
  assign irq_id = r_irq_id;
  assign in_isr = (r_state == IN_ISR);

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - scoreboard bench with reference model for irq_controller
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq_in;
  logic [3:0]  irq_mask;
  logic        gie;
  logic [1:0]  pc_src_in;
  logic [31:0] pc_plus4;
  logic        iret;
  logic [1:0]  pc_src_out;
  logic [31:0] epc;
  logic [1:0]  irq_id;
  logic [3:0]  irq_ack;
  logic        in_isr;

  always #5 clk = ~clk;

  irq_controller #(.N_IRQ(4), .IRQ_ID_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .irq_mask   (irq_mask),
    .gie        (gie),
    .pc_src_in  (pc_src_in),
    .pc_plus4   (pc_plus4),
    .iret       (iret),
    .pc_src_out (pc_src_out),
    .epc        (epc),
    .irq_id     (irq_id),
    .irq_ack    (irq_ack),
    .in_isr     (in_isr)
  );

  typedef struct {
    logic [1:0]  pc;
    logic [3:0]  ack;
    logic [31:0] epc;
    logic [1:0]  id;
    logic        isr;
    bit          regs;
  } exp_t;

  exp_t q[$];
  int n_pass = 0;
  int n_total = 0;

  bit          m_pend[4];
  bit          m_prev[4];
  bit          m_sync1[4];
  bit          m_sync2[4];
  bit          m_isr;
  logic [1:0]  m_id;
  logic [31:0] m_epc;
  bit          m_known = 1'b0;

  task automatic ck(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic ck_d(input string name, input logic [31:0] act, input logic [31:0] exp);
`ifndef IRQ_SYNC_EN
    ck(name, act, exp);
`endif
  endtask

  task automatic cyc(input bit rst, input logic [3:0] irq, input logic [3:0] mask,
                     input bit g, input logic [1:0] pcs, input logic [31:0] pc4,
                     input bit ir);
    exp_t e;
    int   win;
    bit   take;
    bit   s[4];
    @(posedge clk);
    #1;
    reset = rst; irq_in = irq; irq_mask = mask; gie = g;
    pc_src_in = pcs; pc_plus4 = pc4; iret = ir;

    win = -1;
    for (int i = 0; i < 4; i++)
      if (m_pend[i] && !mask[i] && win < 0) win = i;
    take = !rst && !m_isr && g && (win >= 0) && (pcs == 2'b00) && !ir;
    e.pc   = rst ? pcs : take ? 2'b10 : (m_isr && ir) ? 2'b11 : pcs;
    e.ack  = take ? 4'(1 << win) : 4'b0000;
    e.epc  = m_epc;
    e.id   = m_id;
    e.isr  = m_isr;
    e.regs = m_known;
    q.push_back(e);

    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_pend[i] = 0; m_prev[i] = 1; m_sync1[i] = 1; m_sync2[i] = 1;
      end
      m_isr = 0; m_epc = 0; m_id = 0; m_known = 1;
    end else begin
      for (int i = 0; i < 4; i++) begin
`ifdef IRQ_SYNC_EN
        s[i] = m_sync2[i];
`else
        s[i] = irq[i];
`endif
        m_pend[i]  = (m_pend[i] && !(take && win == i)) || (s[i] && !m_prev[i]);
        m_prev[i]  = s[i];
        m_sync2[i] = m_sync1[i];
        m_sync1[i] = irq[i];
      end
      if (take) begin
        m_epc = pc4; m_id = 2'(win); m_isr = 1;
      end else if (m_isr && ir) begin
        m_isr = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      ck("pc_src_out", 32'(pc_src_out), 32'(e.pc));
      ck("irq_ack", 32'(irq_ack), 32'(e.ack));
      if (e.regs) begin
        ck("epc", epc, e.epc);
        ck("irq_id", 32'(irq_id), 32'(e.id));
        ck("in_isr", 32'(in_isr), 32'(e.isr));
      end
    end
  end

  initial begin
    logic [3:0]  r_irq;
    logic [3:0]  r_mask;
    logic [1:0]  r_pcs;
    reset = 1; irq_in = 0; irq_mask = 0; gie = 0; pc_src_in = 0; pc_plus4 = 0; iret = 0;

    // held line through reset, then basic dispatch of line 2
    cyc(1, 4'b0001, 4'b0000, 1, 2'b00, 32'h20, 0);
    cyc(1, 4'b0001, 4'b0000, 1, 2'b00, 32'h20, 0);
    cyc(0, 4'b0001, 4'b0000, 1, 2'b00, 32'h20, 0);
    @(negedge clk); ck_d("held_line_ack", 32'(irq_ack), 0);
    cyc(0, 4'b0101, 4'b0000, 1, 2'b00, 32'h20, 0);
    cyc(0, 4'b0001, 4'b0000, 1, 2'b00, 32'h20, 0);
    @(negedge clk); ck_d("basic_pc", 32'(pc_src_out), 2); ck_d("basic_ack", 32'(irq_ack), 4'b0100);
    cyc(0, 4'b0001, 4'b0000, 1, 2'b00, 32'h20, 0);
    @(negedge clk); ck_d("basic_epc", epc, 32'h20); ck_d("basic_id", 32'(irq_id), 2);
    ck_d("basic_isr", 32'(in_isr), 1);
    cyc(0, 4'b0001, 4'b0000, 1, 2'b00, 32'h20, 1);
    @(negedge clk); ck_d("basic_ret", 32'(pc_src_out), 3);

    // priority: lines 3 and 1 together
    cyc(0, 4'b1011, 4'b0000, 1, 2'b00, 32'h40, 0);
    cyc(0, 4'b0001, 4'b0000, 1, 2'b00, 32'h40, 0);
    @(negedge clk); ck_d("prio_first", 32'(irq_ack), 4'b0010);
    cyc(0, 4'b0001, 4'b0000, 1, 2'b00, 32'h44, 1);
    cyc(0, 4'b0001, 4'b0000, 1, 2'b00, 32'h48, 0);
    @(negedge clk); ck_d("prio_second", 32'(irq_ack), 4'b1000);
    cyc(0, 4'b0001, 4'b0000, 1, 2'b00, 32'h48, 1);

    // branch deferral
    cyc(0, 4'b0000, 4'b0000, 1, 2'b00, 32'h50, 0);
    cyc(0, 4'b0001, 4'b0000, 1, 2'b00, 32'h50, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 4'b0001, 4'b0000, 1, 2'b01, 32'h54, 0);
      @(negedge clk); ck_d("defer_pc", 32'(pc_src_out), 1);
    end
    cyc(0, 4'b0001, 4'b0000, 1, 2'b00, 32'h58, 0);
    @(negedge clk); ck_d("defer_take", 32'(irq_ack), 4'b0001);
    cyc(0, 4'b0000, 4'b0000, 1, 2'b00, 32'h58, 1);

    // mask then gie
    cyc(0, 4'b0001, 4'b0001, 1, 2'b00, 32'h60, 0);
    cyc(0, 4'b0001, 4'b0001, 1, 2'b00, 32'h60, 0);
    @(negedge clk); ck_d("masked", 32'(irq_ack), 0);
    cyc(0, 4'b0001, 4'b0000, 1, 2'b00, 32'h60, 0);
    @(negedge clk); ck_d("unmasked", 32'(irq_ack), 4'b0001);
    cyc(0, 4'b0000, 4'b0000, 1, 2'b00, 32'h60, 1);
    cyc(0, 4'b0100, 4'b0000, 0, 2'b00, 32'h64, 0);
    cyc(0, 4'b0100, 4'b0000, 0, 2'b00, 32'h64, 0);
    @(negedge clk); ck_d("gie_off", 32'(irq_ack), 0);
    cyc(0, 4'b0100, 4'b0000, 1, 2'b00, 32'h64, 0);
    @(negedge clk); ck_d("gie_on", 32'(irq_ack), 4'b0100);
    cyc(0, 4'b0000, 4'b0000, 1, 2'b00, 32'h64, 1);

    // no nesting, re-pend on the clearing cycle
    cyc(0, 4'b0010, 4'b0010, 1, 2'b00, 32'h70, 0);
    cyc(0, 4'b0000, 4'b0010, 1, 2'b00, 32'h70, 0);
    cyc(0, 4'b0010, 4'b0000, 1, 2'b00, 32'h70, 0);
    @(negedge clk); ck_d("nest_take1", 32'(irq_ack), 4'b0010);
    cyc(0, 4'b0011, 4'b0000, 1, 2'b00, 32'h74, 0);
    cyc(0, 4'b0011, 4'b0000, 1, 2'b00, 32'h74, 0);
    @(negedge clk); ck_d("no_nest", 32'(irq_ack), 0);
    cyc(0, 4'b0011, 4'b0000, 1, 2'b00, 32'h74, 1);
    cyc(0, 4'b0011, 4'b0000, 1, 2'b00, 32'h78, 0);
    @(negedge clk); ck_d("nest_line0", 32'(irq_ack), 4'b0001);
    cyc(0, 4'b0011, 4'b0000, 1, 2'b00, 32'h78, 1);
    cyc(0, 4'b0011, 4'b0000, 1, 2'b00, 32'h7c, 0);
    @(negedge clk); ck_d("repend_line1", 32'(irq_ack), 4'b0010);
    cyc(0, 4'b0011, 4'b0000, 1, 2'b00, 32'h7c, 1);

    // reset mid-ISR with a pending line
    cyc(0, 4'b0111, 4'b0000, 1, 2'b00, 32'h80, 0);
    cyc(0, 4'b0111, 4'b0000, 1, 2'b00, 32'h80, 0);
    cyc(0, 4'b1111, 4'b0000, 1, 2'b00, 32'h84, 0);
    cyc(1, 4'b1111, 4'b0000, 1, 2'b01, 32'h84, 1);
    @(negedge clk); ck_d("rst_pc", 32'(pc_src_out), 1); ck_d("rst_ack", 32'(irq_ack), 0);
    cyc(0, 4'b1111, 4'b0000, 1, 2'b00, 32'h88, 0);
    @(negedge clk); ck_d("rst_isr", 32'(in_isr), 0); ck_d("rst_epc", epc, 0);
    ck_d("rst_pend", 32'(irq_ack), 0);

    // randomized traffic
    r_irq = 4'b1111;
    for (int n = 0; n < 3000; n++) begin
      r_irq  = r_irq ^ (4'($urandom) & 4'($urandom));
      r_mask = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      r_pcs  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      cyc(($urandom_range(0, 99) == 0), r_irq, r_mask, ($urandom_range(0, 7) != 0),
          r_pcs, $urandom & 32'hffff_fffc, ($urandom_range(0, 5) == 0));
    end

    @(negedge clk);
    #1;
    ck("queue_drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
